// File: rtl/keypad_pkg.sv
// Shared constants and state encoding for the keypad entry stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package keypad_pkg;

    localparam int KEY_W        = 10;  // one bit per decimal key
    localparam int BCD_W        = 4;   // width of each BCD digit register
    localparam int MAX_SEC_TENS = 5;   // largest seconds-tens digit accepted at start

    localparam logic [BCD_W-1:0] ZERO_BCD = '0;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ENTRY  = 2'd1,
        S_LOAD   = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

endpackage

// File: rtl/keypad_entry_key_encoder.sv
// Encodes a one-hot keypad vector into a BCD digit and flags whether exactly one key is set.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input.
//
// Ports:
//   keypad    - raw key levels, bit i = digit i
//   digit     - index of the set bit (only meaningful when onehot_ok)
//   onehot_ok - exactly one key bit is set
module key_encoder
    import keypad_pkg::*;
(
    input  logic [KEY_W-1:0] keypad,
    output logic [BCD_W-1:0] digit,
    output logic             onehot_ok
);

    // Clearing the lowest set bit leaves zero only for a single-bit vector.
    assign onehot_ok = (keypad != '0) && ((keypad & (keypad - KEY_W'(1))) == '0);

    always_comb begin
        digit = ZERO_BCD;
        for (int i = 0; i < KEY_W; i++) begin
            if (keypad[i]) begin
                digit = BCD_W'(i);
            end
        end
    end

endmodule

// File: rtl/keypad_entry.sv
// Shifts keypad digits into mins/sec_tens/sec_ones, validates on start, pulses loadn to the counters, then locks.
// Latency: all outputs registered; a press or start is reflected one clock after it is sampled.
// Backpressure: none; entry is simply ignored while busy (LOAD/LOCKED) until cnt_zero or cancel.
//
// Ports:
//   clk, clearn                 - clock and synchronous active-low clear
//   keypad, start, cancel       - user inputs (levels)
//   cnt_zero                    - counter chain reached zero
//   mins, sec_tens, sec_ones    - BCD time value to the counters
//   loadn                       - one-cycle active-low load strobe
//   busy                        - high while loading or locked
//   key_err                     - one-cycle error pulse
module keypad_entry
    import keypad_pkg::*;
(
    input  logic             clk,
    input  logic             clearn,
    input  logic [KEY_W-1:0] keypad,
    input  logic             start,
    input  logic             cancel,
    input  logic             cnt_zero,
    output logic [BCD_W-1:0] mins,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             loadn,
    output logic             busy,
    output logic             key_err
);

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_prev_q, key_prev_d;
    logic [BCD_W-1:0] mins_q, mins_d;
    logic [BCD_W-1:0] sec_tens_q, sec_tens_d;
    logic [BCD_W-1:0] sec_ones_q, sec_ones_d;
    logic             loadn_q, loadn_d;
    logic             key_err_q, key_err_d;

    logic [BCD_W-1:0] key_digit;
    logic             key_onehot;
    logic             press;
    logic             entry_ok;
    logic             shift_en;
    logic             clear_en;

    key_encoder u_key_encoder (
        .keypad    (keypad),
        .digit     (key_digit),
        .onehot_ok (key_onehot)
    );

    // Only a transition out of the all-released state counts, so a held key never repeats.
    assign press = (key_prev_q == '0) && (keypad != '0);

    assign entry_ok = ({mins_q, sec_tens_q, sec_ones_q} != '0) &&
                      (sec_tens_q <= BCD_W'(MAX_SEC_TENS));

    always_comb begin
        state_d    = state_q;
        key_prev_d = keypad;
        loadn_d    = 1'b1;
        key_err_d  = 1'b0;
        shift_en   = 1'b0;
        clear_en   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cancel) begin
                    clear_en = 1'b1;
                end else if (start) begin
                    key_err_d = 1'b1;
                end else if (press) begin
                    if (key_onehot) begin
                        shift_en = 1'b1;
                        state_d  = S_ENTRY;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
            end
            S_ENTRY: begin
                if (cancel) begin
                    clear_en = 1'b1;
                    state_d  = S_IDLE;
                end else if (start) begin
                    if (entry_ok) begin
                        // loadn is registered, so it goes low together with state LOAD.
                        loadn_d = 1'b0;
                        state_d = S_LOAD;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end else if (press) begin
                    if (key_onehot) begin
                        shift_en = 1'b1;
                    end else begin
                        key_err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                state_d = S_LOCKED;
            end
            S_LOCKED: begin
                if (cancel || cnt_zero) begin
                    clear_en = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        mins_d     = mins_q;
        sec_tens_d = sec_tens_q;
        sec_ones_d = sec_ones_q;
        if (clear_en) begin
            mins_d     = ZERO_BCD;
            sec_tens_d = ZERO_BCD;
            sec_ones_d = ZERO_BCD;
        end else if (shift_en) begin
            // Oldest digit (mins) falls off the top.
            mins_d     = sec_tens_q;
            sec_tens_d = sec_ones_q;
            sec_ones_d = key_digit;
        end
    end

    always_ff @(posedge clk) begin
        if (!clearn) begin
            state_q    <= S_IDLE;
            key_prev_q <= '0;
            mins_q     <= ZERO_BCD;
            sec_tens_q <= ZERO_BCD;
            sec_ones_q <= ZERO_BCD;
            loadn_q    <= 1'b1;
            key_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_prev_q <= key_prev_d;
            mins_q     <= mins_d;
            sec_tens_q <= sec_tens_d;
            sec_ones_q <= sec_ones_d;
            loadn_q    <= loadn_d;
            key_err_q  <= key_err_d;
        end
    end

    assign mins     = mins_q;
    assign sec_tens = sec_tens_q;
    assign sec_ones = sec_ones_q;
    assign loadn    = loadn_q;
    assign key_err  = key_err_q;
    assign busy     = (state_q == S_LOAD) || (state_q == S_LOCKED);

endmodule
